// File: rtl/proteus_psum_accum.sv
// ---------------------------------------------------------------------------
// proteus_psum_accum
//
// NFU-2 partial-sum accumulator. It accumulates Tn signed lanes over a job of
// `passes` input beats. The starting value is either zero or a seed vector
// reloaded from NBout. When the job completes, the block presents one
// saturated result vector. That vector is held under backpressure and tagged
// final (to NFU-3) or partial (written back to NBout).
//
// Optional build macro:
//   PROTEUS_PSUM_SAT_STATS_EN - builds the saturation event counter that
//                               drives o_sat_cnt. When the macro is
//                               undefined, o_sat_cnt is tied to zero.
//
// Ports:
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   i_start               job start pulse, honoured only in IDLE
//   i_passes              beats per job (0 behaves as 1)
//   i_seed_en, i_seed     at start: initialise the accumulator from i_seed
//                         when i_seed_en is 1, otherwise from zero
//   i_final               at start: result tag (1 = final, 0 = partial)
//   i_abort               synchronous job cancel (highest priority)
//   i_in_valid/o_in_ready input beat handshake, data on i_in_data
//   o_out_valid/i_out_ready result handshake, data on o_out_data
//   o_out_final           tag latched at start
//   o_busy                high whenever the state is not IDLE
//   o_sat_cnt             number of input fires in which any lane clamped
// ---------------------------------------------------------------------------
module proteus_psum_accum #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_passes,
  input  logic                    i_seed_en,
  input  logic [BIT_WIDTH*Tn-1:0] i_seed,
  input  logic                    i_final,
  input  logic                    i_abort,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [BIT_WIDTH*Tn-1:0] i_in_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BIT_WIDTH*Tn-1:0] o_out_data,
  output logic                    o_out_final,
  output logic                    o_busy,
  output logic [15:0]             o_sat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int VW = BIT_WIDTH * Tn;

  state_e            state_q, state_d;
  logic [VW-1:0]     acc_q, acc_d;
  logic [VW-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  passes_q, passes_d;
  logic              final_q, final_d;

  logic [VW-1:0]     acc_sum;
  logic              start_ok;
  logic              in_fire;

  // Abort wins over both a start in IDLE and a beat in ACCUM.
  assign start_ok = (state_q == ST_IDLE)  && i_start    && !i_abort;
  assign in_fire  = (state_q == ST_ACCUM) && i_in_valid && !i_abort;

`ifdef PROTEUS_PSUM_SAT_STATS_EN
  logic [Tn-1:0] lane_clamp;
`endif

  // Per-lane saturating add. The sum is computed one bit wider, so overflow
  // shows up as disagreement between the top two bits. The top bit of the
  // wide sum then gives the true sign, which selects the clamp direction.
  for (genvar gi = 0; gi < Tn; gi++) begin : g_lane
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic [BIT_WIDTH:0]   sum;
    logic                 ovf;

    assign a   = acc_q[gi*BIT_WIDTH +: BIT_WIDTH];
    assign b   = i_in_data[gi*BIT_WIDTH +: BIT_WIDTH];
    assign sum = {a[BIT_WIDTH-1], a} + {b[BIT_WIDTH-1], b};
    assign ovf = sum[BIT_WIDTH] ^ sum[BIT_WIDTH-1];

    assign acc_sum[gi*BIT_WIDTH +: BIT_WIDTH] =
        !ovf           ? sum[BIT_WIDTH-1:0] :
        sum[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}} :
                         {1'b0, {(BIT_WIDTH-1){1'b1}}};

`ifdef PROTEUS_PSUM_SAT_STATS_EN
    assign lane_clamp[gi] = ovf;
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    passes_d   = passes_q;
    final_d    = final_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          passes_d = (i_passes == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : i_passes;
          final_d  = i_final;
          acc_d    = i_seed_en ? i_seed : '0;
          cnt_d    = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (in_fire) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          // The final beat publishes the same-cycle sum directly.
          if (cnt_q == passes_q - 1'b1) begin
            out_data_d = acc_sum;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (i_abort || i_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      passes_q   <= '0;
      final_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
      passes_q   <= passes_d;
      final_q    <= final_d;
    end
  end

`ifdef PROTEUS_PSUM_SAT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (start_ok) begin
      sat_cnt_d = '0;
    end else if (in_fire && (|lane_clamp) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`else
  assign o_sat_cnt = 16'd0;
`endif

  assign o_in_ready  = (state_q == ST_ACCUM);
  assign o_out_valid = (state_q == ST_HOLD);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_out_data  = out_data_q;
  assign o_out_final = final_q;

endmodule

// File: tb/tb_proteus_psum_accum.sv
module tb_proteus_psum_accum;

  localparam int BW = 16;
  localparam int TN = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic [CW-1:0]   i_passes;
  logic            i_seed_en;
  logic [BW*TN-1:0] i_seed;
  logic            i_final;
  logic            i_abort;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [BW*TN-1:0] i_in_data;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [BW*TN-1:0] o_out_data;
  logic            o_out_final;
  logic            o_busy;
  logic [15:0]     o_sat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  proteus_psum_accum #(.BIT_WIDTH(BW), .Tn(TN), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_passes   (i_passes),
    .i_seed_en  (i_seed_en),
    .i_seed     (i_seed),
    .i_final    (i_final),
    .i_abort    (i_abort),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_out_final(o_out_final),
    .o_busy     (o_busy),
    .o_sat_cnt  (o_sat_cnt)
  );

  function automatic logic [63:0] vec4(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse i_start for one cycle; returns at edge+1 with the DUT in ACCUM.
  task automatic do_start(input logic [CW-1:0] passes, input logic seed_en,
                          input logic [63:0] seed, input logic fin);
    i_start   = 1'b1;
    i_passes  = passes;
    i_seed_en = seed_en;
    i_seed    = seed;
    i_final   = fin;
    tick();
    i_start   = 1'b0;
    i_seed_en = 1'b0;
    i_seed    = '0;
  endtask

  task automatic beat(input logic [63:0] d);
    i_in_valid = 1'b1;
    i_in_data  = d;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_out_valid, o_in_ready, o_out_final, o_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {o_out_valid, o_in_ready, o_out_final, o_busy});
    end
    checks++;
    if (o_out_data !== 64'd0 || o_sat_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_data got data=%h sat=%h exp=0", o_out_data, o_sat_cnt);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_basic();
    do_start(8'd3, 1'b0, 64'd0, 1'b1);
    checks++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_accum_state got ready=%b busy=%b exp=1,1", o_in_ready, o_busy);
    end
    i_in_valid = 1'b1;
    i_in_data  = vec4(16'd1, 16'd2, 16'd3, 16'd4);
    tick();
    tick();
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b exp=0", o_out_valid);
    end
    tick();
    i_in_valid = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== vec4(16'd3, 16'd6, 16'd9, 16'd12)) begin
      failures++;
      $display("FAIL basic_result got valid=%b data=%h exp=1 %h", o_out_valid, o_out_data,
               vec4(16'd3, 16'd6, 16'd9, 16'd12));
    end
    checks++;
    if (o_out_final !== 1'b1) begin
      failures++;
      $display("FAIL basic_final got=%b exp=1", o_out_final);
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept got valid=%b busy=%b exp=0,0", o_out_valid, o_busy);
    end
    $display("basic: passes=3 data=%h", vec4(16'd3, 16'd6, 16'd9, 16'd12));
  endtask

  task automatic test_seed();
    do_start(8'd0, 1'b1, vec4(16'd100, 16'hFF9C, 16'd0, 16'd7), 1'b0);
    beat(vec4(16'd1, 16'd1, 16'd1, 16'd1));
    checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== vec4(16'd101, 16'hFF9D, 16'd1, 16'd8)) begin
      failures++;
      $display("FAIL seed_result got valid=%b data=%h exp=1 %h", o_out_valid, o_out_data,
               vec4(16'd101, 16'hFF9D, 16'd1, 16'd8));
    end
    checks++;
    if (o_out_final !== 1'b0) begin
      failures++;
      $display("FAIL seed_final got=%b exp=0", o_out_final);
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    $display("seed: passes=0 data=%h", vec4(16'd101, 16'hFF9D, 16'd1, 16'd8));
  endtask

  task automatic test_saturation();
    logic [15:0] exp_sat;
`ifdef PROTEUS_PSUM_SAT_STATS_EN
    exp_sat = 16'd1;
`else
    exp_sat = 16'd0;
`endif
    do_start(8'd1, 1'b1, vec4(16'h7FFE, 16'h8001, 16'h7000, 16'h9000), 1'b1);
    // Lanes 2/3 stay in range, so only lanes 0/1 clamp.
    beat(vec4(16'd5, 16'hFFFB, 16'h0FFF, 16'hF000));
    checks++;
    if (o_out_data !== vec4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000)) begin
      failures++;
      $display("FAIL sat_result got=%h exp=%h", o_out_data,
               vec4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000));
    end
    checks++;
    if (o_sat_cnt !== exp_sat) begin
      failures++;
      $display("FAIL sat_cnt got=%0d exp=%0d", o_sat_cnt, exp_sat);
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    $display("saturation: data=%h sat_cnt=%0d", o_out_data, o_sat_cnt);
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_d;
    exp_d = vec4(16'd11, 16'd21, 16'd31, 16'd41);
    do_start(8'd2, 1'b0, 64'd0, 1'b0);
    beat(vec4(16'd10, 16'd20, 16'd30, 16'd40));
    tick();  // bubble
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_bubble got valid=%b ready=%b exp=0,1", o_out_valid, o_in_ready);
    end
    beat(vec4(16'd1, 16'd1, 16'd1, 16'd1));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_out_data !== exp_d) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b ready=%b data=%h exp=1,0,%h",
                 i, o_out_valid, o_in_ready, o_out_data, exp_d);
      end
      // Stray input beats during HOLD must not disturb the result.
      i_in_valid = 1'b1;
      i_in_data  = vec4(16'd9, 16'd9, 16'd9, 16'd9);
      tick();
      i_in_valid = 1'b0;
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got valid=%b busy=%b exp=0,0", o_out_valid, o_busy);
    end
    $display("backpressure: data=%h", exp_d);
  endtask

  task automatic test_start_ignored();
    do_start(8'd2, 1'b0, 64'd0, 1'b1);
    beat(vec4(16'd1, 16'd1, 16'd1, 16'd1));
    // Start with different parameters alongside the final beat.
    i_start   = 1'b1;
    i_passes  = 8'd5;
    i_seed_en = 1'b1;
    i_seed    = vec4(16'd50, 16'd50, 16'd50, 16'd50);
    i_final   = 1'b0;
    beat(vec4(16'd1, 16'd1, 16'd1, 16'd1));
    i_start   = 1'b0;
    i_seed_en = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== vec4(16'd2, 16'd2, 16'd2, 16'd2)
        || o_out_final !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored got valid=%b data=%h final=%b exp=1 %h 1",
               o_out_valid, o_out_data, o_out_final, vec4(16'd2, 16'd2, 16'd2, 16'd2));
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    $display("start_ignored: data=%h", vec4(16'd2, 16'd2, 16'd2, 16'd2));
  endtask

  task automatic test_abort();
    do_start(8'd2, 1'b0, 64'd0, 1'b0);
    beat(vec4(16'd3, 16'd3, 16'd3, 16'd3));
    i_abort = 1'b1;
    beat(vec4(16'd3, 16'd3, 16'd3, 16'd3));
    i_abort = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_final_fire got valid=%b busy=%b exp=0,0", o_out_valid, o_busy);
    end
    // Abort in IDLE beats a same-cycle start.
    i_abort = 1'b1;
    do_start(8'd1, 1'b0, 64'd0, 1'b1);
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle_start got busy=%b exp=0", o_busy);
    end
    $display("abort: discarded");
  endtask

  task automatic test_async_reset();
    do_start(8'd3, 1'b0, 64'd0, 1'b1);
    beat(vec4(16'd1, 16'd1, 16'd1, 16'd1));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_out_valid, o_in_ready, o_out_final, o_busy} !== 4'b0000 || o_out_data !== 64'd0) begin
      failures++;
      $display("FAIL async_reset got ctrl=%b data=%h exp=0000 0",
               {o_out_valid, o_in_ready, o_out_final, o_busy}, o_out_data);
    end
    #2;
    rst_n = 1'b1;
    tick();
    $display("async_reset: cleared mid-accum");
  endtask

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_passes    = '0;
    i_seed_en   = 1'b0;
    i_seed      = '0;
    i_final     = 1'b0;
    i_abort     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_seed();
    test_saturation();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proteus_psum_accum.md
Name: proteus_psum_accum

Overview:
- Parametrised NFU-2 partial-sum accumulator with a ready/valid handshake. It sits between the NFU-2 adder trees and NFU-3/NBout.
- Accumulates Tn lanes of signed partial sums over a configurable number of passes. The start value is zero or a seed vector reloaded from NBout.
- Emits one saturated result vector per job and holds it under backpressure. The output is tagged final (goes to NFU-3) or partial (written back to NBout).

Parameters:
- BIT_WIDTH, 16, bits per lane (signed two's complement).
- Tn, 16, number of lanes.
- CNT_W, 8, width of the pass counter; max passes = 2^CNT_W - 1.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  job start pulse; honoured only in IDLE.
- i_passes  in  CNT_W  number of input beats for the job; 0 is treated as 1.
- i_seed_en  in  1  at start: 1 = initialise from i_seed, 0 = initialise to zero.
- i_seed  in  BIT_WIDTH*Tn  seed vector from NBout.
- i_final  in  1  at start: tag for the result (1 = final/NFU-3, 0 = partial/NBout).
- i_abort  in  1  synchronous job cancel.
- i_in_valid  in  1  input beat valid.
- o_in_ready  out  1  accumulator ready for an input beat.
- i_in_data  in  BIT_WIDTH*Tn  NFU-2 per-lane sums; lane k occupies bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  downstream accept.
- o_out_data  out  BIT_WIDTH*Tn  accumulated result.
- o_out_final  out  1  tag latched at start.
- o_busy  out  1  high whenever the state is not IDLE.
- o_sat_cnt  out  16  saturation event count; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Accumulator, counter, o_out_data and o_sat_cnt clear to 0.
  - o_out_valid, o_in_ready, o_out_final and o_busy are 0.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - o_in_ready = 0.
  - On i_start:
    - Latch passes (passes = max(i_passes, 1)) and i_final.
    - acc <= i_seed_en ? i_seed : 0.
    - cnt <= 0.
    - Next state is ACCUM.
- ACCUM:
  - o_in_ready = 1.
  - A beat fires when i_in_valid and o_in_ready are both high. On a fire:
    - Each lane updates acc[k] <= sat(acc[k] + in[k]).
    - cnt increments.
  - On the fire where cnt == passes-1:
    - o_out_data <= the updated acc value (the same-cycle sum).
    - o_out_valid is asserted the next cycle.
    - Next state is HOLD.
  - Beats with i_in_valid low are bubbles: no state change.
- HOLD:
  - o_out_valid = 1; o_in_ready = 0.
  - o_out_data and o_out_final stay stable until accepted.
  - On i_out_ready, go to IDLE and drop o_out_valid the following cycle.
- Latency: result valid exactly 1 cycle after the last input fire. Throughput is 1 beat per cycle in ACCUM.
- Saturating arithmetic:
  - Compute a BIT_WIDTH+1 bit sum.
  - If the sum exceeds 2^(BIT_WIDTH-1)-1, clamp to the maximum positive value.
  - If the sum is below -2^(BIT_WIDTH-1), clamp to the minimum negative value.
  - Each lane saturates independently.
- i_start outside IDLE is ignored; no latching occurs.
- i_abort:
  - In ACCUM or HOLD: go to IDLE next cycle, clear o_out_valid, discard the result.
  - i_abort has priority over a same-cycle input fire or output accept.
  - In IDLE, i_abort has priority over i_start.
- Single-beat job (passes 0 or 1): ACCUM lasts exactly until the first fire.
- i_in_valid while not in ACCUM: no effect.

Optional Feature:
- Macro PROTEUS_PSUM_SAT_STATS_EN.
- Defined:
  - o_sat_cnt increments by 1 on each input fire where at least one lane clamped.
  - The counter sticks at 0xFFFF.
  - It clears to 0 on an honoured i_start.
- Not defined: o_sat_cnt is constant 0 and no counter logic is built.

Test Plan (Tn=4, BIT_WIDTH=16):
- Reset release, start with passes=3, seed_en=0. Feed beats {1,2,3,4} three times back-to-back. Expect o_out_data={3,6,9,12} exactly 1 cycle after the third fire, and o_out_final equal to the latched i_final.
- Start with seed_en=1, seed={100,-100,0,7}, passes=0. Feed one beat {1,1,1,1}. Expect {101,-99,1,8}, valid 1 cycle later.
- Saturation: seed lane0=0x7FFE with input +5; lane1=0x8001 with input -5. Expect lane0=0x7FFF and lane1=0x8000. With the macro defined, o_sat_cnt=1; without it, o_sat_cnt=0.
- Backpressure and bubbles: passes=2 with a bubble between beats. Hold i_out_ready=0 for 5 cycles. o_out_valid and o_out_data stay stable and o_in_ready=0 throughout. On accept, the block returns to IDLE and o_busy=0.
- Mid-job disruption:
  - i_start while in ACCUM is ignored; the result is unchanged.
  - i_abort asserted on the same cycle as the final fire gives no o_out_valid and IDLE next cycle.
  - rst_n low mid-ACCUM clears all outputs immediately (asynchronously).
